dsky_keyboard: RTL

- Keyboard-side transmitter for the DSKY. Drives input channel 015 and the KEYRUPT1 request toward the agc core; the core is the receiver of this interface.
- Takes raw key contacts and debounces them. Encodes each accepted press into the 5-bit AGC keycode and queues it until the core reads channel 015.
- The PRO key bypasses the keycode path and drives the channel 032 bit-14 level.

---
 rtl/dsky_keyboard_pkg.sv | 60 ++++++
 rtl/dsky_key_fifo.sv | 68 ++++++
 rtl/dsky_keyboard.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dsky_keyboard_pkg.sv
// DSKY keyboard shared definitions: key indices, AGC keycodes,
// scan FSM states and the index-to-keycode encoder.
package dsky_keyboard_pkg;

  localparam int NUM_KEYS = 18;

  localparam logic [4:0] KEY_VERB   = 5'd10;
  localparam logic [4:0] KEY_NOUN   = 5'd11;
  localparam logic [4:0] KEY_PLUS   = 5'd12;
  localparam logic [4:0] KEY_MINUS  = 5'd13;
  localparam logic [4:0] KEY_CLR    = 5'd14;
  localparam logic [4:0] KEY_KEYREL = 5'd15;
  localparam logic [4:0] KEY_ENTR   = 5'd16;
  localparam logic [4:0] KEY_RSET   = 5'd17;

  localparam logic [4:0] KC_ZERO   = 5'o20;
  localparam logic [4:0] KC_VERB   = 5'o21;
  localparam logic [4:0] KC_RSET   = 5'o22;
  localparam logic [4:0] KC_KEYREL = 5'o31;
  localparam logic [4:0] KC_PLUS   = 5'o32;
  localparam logic [4:0] KC_MINUS  = 5'o33;
  localparam logic [4:0] KC_ENTR   = 5'o34;
  localparam logic [4:0] KC_CLR    = 5'o36;
  localparam logic [4:0] KC_NOUN   = 5'o37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_PUSH,
    ST_WAIT_REL,
    ST_REL_DB
  } kbd_state_t;

  function automatic logic [4:0] encode_key(input logic [4:0] idx);
    logic [4:0] code;
    code = 5'd0;
    if (idx >= 5'd1 && idx <= 5'd9) begin
      code = idx;
    end else begin
      case (idx)
        5'd0:       code = KC_ZERO;
        KEY_VERB:   code = KC_VERB;
        KEY_NOUN:   code = KC_NOUN;
        KEY_PLUS:   code = KC_PLUS;
        KEY_MINUS:  code = KC_MINUS;
        KEY_CLR:    code = KC_CLR;
        KEY_KEYREL: code = KC_KEYREL;
        KEY_ENTR:   code = KC_ENTR;
        KEY_RSET:   code = KC_RSET;
        default:    code = 5'd0;
      endcase
    end
    return code;
  endfunction

  function automatic logic can_repeat(input logic [4:0] idx);
    return (idx <= 5'd9) || (idx == KEY_CLR);
  endfunction

endpackage

// File: rtl/dsky_key_fifo.sv
// Keycode queue: synchronous circular FIFO, power-of-two depth.
// A push into a full queue is accepted when a pop happens the same cycle.
module dsky_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = empty ? '0 : mem_q[rd_q];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dsky_keyboard.sv
// DSKY keyboard transmitter: debounce, keycode queue for channel 015, PRO level.
// Optional key auto-repeat is enabled by defining DSKY_KBD_AUTOREPEAT_EN.
module dsky_keyboard
  import dsky_keyboard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] keys,
  input  logic        pro_key,
  input  logic        chan_rd_15,
  output logic [4:0]  chan15_data,
  output logic        keyrupt_req,
  output logic        chan32_pro_n,
  output logic        key_overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  kbd_state_t    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          ovf_q, ovf_d;
  logic          pro_q, pro_d;
  logic [CW-1:0] pro_cnt_q, pro_cnt_d;

  logic          onehot;
  logic [4:0]    hit_idx;
  logic [17:0]   latched;
  logic          push;
  logic          fifo_full, fifo_empty;
  logic [4:0]    fifo_head;

`ifdef DSKY_KBD_AUTOREPEAT_EN
  localparam int RW = $clog2(16 * DEBOUNCE_CYCLES + 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(16 * DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(4 * DEBOUNCE_CYCLES - 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_first_q, rpt_first_d;
`endif

  assign onehot  = (keys != '0) && ((keys & (keys - 18'd1)) == '0);
  assign latched = 18'd1 << idx_q;

  always_comb begin
    hit_idx = 5'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) hit_idx = 5'(i);
    end
  end

  // armed stays low after reset until all keys have been seen released
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    armed_d = armed_q | (keys == '0);
`ifdef DSKY_KBD_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && onehot) begin
          idx_d   = hit_idx;
          cnt_d   = '0;
          state_d = ST_PRESS_DB;
        end
      end
      ST_PRESS_DB: begin
        if (keys != latched) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_WAIT_REL;
`ifdef DSKY_KBD_AUTOREPEAT_EN
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
`endif
      end
      ST_WAIT_REL: begin
        if (keys == '0) begin
          cnt_d   = '0;
          state_d = ST_REL_DB;
        end
`ifdef DSKY_KBD_AUTOREPEAT_EN
        else if (keys == latched && can_repeat(idx_q)) begin
          if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
            push        = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RW'(1);
          end
        end
`endif
      end
      ST_REL_DB: begin
        if (keys != '0) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | (push & fifo_full & ~chan_rd_15);
  end

  always_comb begin
    pro_d     = pro_q;
    pro_cnt_d = '0;
    if (pro_key != pro_q) begin
      if (pro_cnt_q == CNT_MAX) begin
        pro_d = pro_key;
      end else begin
        pro_cnt_d = pro_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pro_q     <= 1'b0;
      pro_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      ovf_q     <= ovf_d;
      pro_q     <= pro_d;
      pro_cnt_q <= pro_cnt_d;
    end
  end

`ifdef DSKY_KBD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  dsky_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (5)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (encode_key(idx_q)),
    .pop   (chan_rd_15),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign chan15_data  = fifo_head;
  assign keyrupt_req  = ~fifo_empty;
  assign chan32_pro_n = ~pro_q;
  assign key_overflow = ovf_q;

endmodule
